// File: rtl/inj_queue.sv
// Local injection queue: core flits wait here until the router's local input port is free.
// Optional INJ_STARVE_CNT_EN adds a head-of-line starvation counter driving starve.
`ifndef DST_WIDTH
`define DST_WIDTH 4
`endif
`ifndef DST_LIST_WIDTH
`define DST_LIST_WIDTH 16
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 3
`endif

module inj_queue #(
  parameter int DEPTH        = 4,
  parameter int PAYLOAD_W    = 32,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inj_valid,
  input  logic [`DST_WIDTH-1:0]        inj_dst,
  input  logic [`DST_LIST_WIDTH-1:0]   inj_dstList,
  input  logic                         inj_mc,
  input  logic [PAYLOAD_W-1:0]         inj_payload,
  output logic                         inj_ready,
  input  logic                         slot_free,
  output logic                         rc_valid,
  output logic [`DST_WIDTH-1:0]        rc_dst,
  output logic [`DST_LIST_WIDTH-1:0]   rc_dstList,
  output logic                         rc_mc,
  output logic [PAYLOAD_W-1:0]         rc_payload,
  output logic [`PC_INDEX_WIDTH-1:0]   rc_indir,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic                         drop,
  output logic                         starve
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("inj_queue: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  typedef struct packed {
    logic [`DST_WIDTH-1:0]      dst;
    logic [`DST_LIST_WIDTH-1:0] dst_list;
    logic                       mc;
    logic [PAYLOAD_W-1:0]       payload;
  } flit_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_e;

  flit_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] occ_q, occ_d;
  state_e        state_q;
  logic          drop_q;
  logic          push, pop, is_drop, store;
  flit_t         in_flit, head;

  assign inj_ready = (occ_q < OW'(DEPTH));
  assign rc_valid  = (occ_q != '0);

  assign push    = inj_valid && inj_ready;
  assign pop     = rc_valid && slot_free;
  // Multicast with an empty destination set has nowhere to go: swallow it.
  assign is_drop = inj_mc && (inj_dstList == '0);
  assign store   = push && !is_drop;
  assign occ_d   = occ_q + OW'(store) - OW'(pop);

  assign in_flit = '{dst: inj_dst, dst_list: inj_dstList, mc: inj_mc, payload: inj_payload};
  assign head    = mem_q[rd_ptr_q];

  assign rc_dst     = head.dst;
  assign rc_dstList = head.dst_list;
  assign rc_mc      = head.mc;
  assign rc_payload = head.payload;
  assign rc_indir   = `PC_INDEX_WIDTH'(4);
  assign occupancy  = occ_q;
  assign drop       = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      drop_q <= push && is_drop;
      occ_q  <= occ_d;
      if (store) begin
        mem_q[wr_ptr_q] <= in_flit;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case (state_q)
        ST_EMPTY:   if (store) state_q <= ST_PARTIAL;
        ST_PARTIAL: begin
          if (store && !pop && occ_q == OW'(DEPTH - 1))   state_q <= ST_FULL;
          else if (pop && !store && occ_q == OW'(1))      state_q <= ST_EMPTY;
        end
        ST_FULL:    if (pop) state_q <= ST_PARTIAL;
        default:    state_q <= ST_EMPTY;
      endcase
    end
  end

`ifdef INJ_STARVE_CNT_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt_q;
  logic          starve_q;

  // starve trails the counter by one register and drops together with the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else if (!rc_valid || pop) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      if (starve_cnt_q != CW'(STARVE_LIMIT)) starve_cnt_q <= starve_cnt_q + CW'(1);
      starve_q <= (starve_cnt_q == CW'(STARVE_LIMIT));
    end
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_inj_queue.sv
// Directed bench for inj_queue (DEPTH=4): ordering, full/empty edges, drop, starve, async reset.
`ifndef DST_WIDTH
`define DST_WIDTH 4
`endif
`ifndef DST_LIST_WIDTH
`define DST_LIST_WIDTH 16
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 3
`endif

module tb_inj_queue;
  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       inj_valid;
  logic [`DST_WIDTH-1:0]      inj_dst;
  logic [`DST_LIST_WIDTH-1:0] inj_dstList;
  logic                       inj_mc;
  logic [31:0]                inj_payload;
  logic                       inj_ready;
  logic                       slot_free;
  logic                       rc_valid;
  logic [`DST_WIDTH-1:0]      rc_dst;
  logic [`DST_LIST_WIDTH-1:0] rc_dstList;
  logic                       rc_mc;
  logic [31:0]                rc_payload;
  logic [`PC_INDEX_WIDTH-1:0] rc_indir;
  logic [2:0]                 occupancy;
  logic                       drop;
  logic                       starve;

  int n_cmp = 0;
  int n_bad = 0;

  inj_queue #(.DEPTH(4), .PAYLOAD_W(32), .STARVE_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .inj_valid(inj_valid), .inj_dst(inj_dst), .inj_dstList(inj_dstList),
    .inj_mc(inj_mc), .inj_payload(inj_payload), .inj_ready(inj_ready),
    .slot_free(slot_free), .rc_valid(rc_valid), .rc_dst(rc_dst),
    .rc_dstList(rc_dstList), .rc_mc(rc_mc), .rc_payload(rc_payload),
    .rc_indir(rc_indir), .occupancy(occupancy), .drop(drop), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int dst, input logic [15:0] lst,
                       input logic mc, input logic sf);
    inj_valid   = v;
    inj_dst     = `DST_WIDTH'(dst);
    inj_dstList = lst;
    inj_mc      = mc;
    inj_payload = 32'hA000_0000 + 32'(dst);
    slot_free   = sf;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 16'h0, 0, 0);
    #2;
    chk("rst_occ", occupancy, 0);
    chk("rst_rc_valid", rc_valid, 0);
    chk("rst_inj_ready", inj_ready, 1);
    chk("rst_drop", drop, 0);
    chk("rst_starve", starve, 0);
    chk("rst_rc_dst_not_x", rc_dst, 0);
    chk("rst_rc_payload_not_x", rc_payload, 0);
    chk("rc_indir", rc_indir, 4);
    #18 rst_n = 1'b1;
    cyc();

    // Three flits through a free slot: head changes every cycle, no bypass.
    drive(1, 1, 16'h1, 0, 1);
    #1 chk("nobypass_rc_valid", rc_valid, 0);
    cyc();
    chk("seq_dst1", rc_dst, 1);
    chk("seq_pay1", rc_payload, 32'hA000_0001);
    drive(1, 2, 16'h1, 0, 1);
    cyc();
    chk("seq_dst2", rc_dst, 2);
    chk("seq_occ2", occupancy, 1);
    drive(1, 3, 16'h1, 0, 1);
    cyc();
    chk("seq_dst3", rc_dst, 3);
    drive(0, 0, 16'h0, 0, 1);
    cyc();
    chk("seq_occ_end", occupancy, 0);
    chk("seq_rc_valid_end", rc_valid, 0);

    // Five push attempts against a blocked slot.
    for (int k = 1; k <= 5; k++) begin
      drive(1, 3 + k, 16'h1, 0, 0);
      cyc();
      chk($sformatf("fill_occ%0d", k), occupancy, (k < 4) ? k : 4);
      chk($sformatf("fill_ready%0d", k), inj_ready, (k < 4) ? 1 : 0);
    end
    chk("fill_head", rc_dst, 4);
    drive(0, 0, 16'h0, 0, 1);
    for (int k = 5; k <= 7; k++) begin
      cyc();
      chk($sformatf("drain_dst%0d", k), rc_dst, k);
    end
    cyc();
    chk("drain_occ", occupancy, 0);

    // Full with simultaneous offer and pop: pop only frees room for the next cycle.
    for (int k = 10; k <= 13; k++) begin
      drive(1, k, 16'h1, 0, 0);
      cyc();
    end
    chk("full_occ", occupancy, 4);
    drive(1, 14, 16'h1, 0, 1);
    #1 chk("full_ready_comb", inj_ready, 0);
    cyc();
    chk("fullpop_occ", occupancy, 3);
    chk("fullpop_ready", inj_ready, 1);
    drive(1, 14, 16'h1, 0, 0);
    cyc();
    chk("refill_occ", occupancy, 4);
    drive(0, 0, 16'h0, 0, 1);
    for (int k = 11; k <= 14; k++) begin
      chk($sformatf("order_dst%0d", k), rc_dst, k);
      cyc();
    end
    chk("order_occ", occupancy, 0);

    // Multicast with empty bitmap is dropped; non-empty multicast is kept.
    drive(1, 7, 16'h0, 1, 0);
    cyc();
    chk("drop_pulse", drop, 1);
    chk("drop_occ", occupancy, 0);
    chk("drop_rc_valid", rc_valid, 0);
    drive(1, 6, 16'h00A5, 1, 0);
    cyc();
    chk("drop_clear", drop, 0);
    chk("mc_occ", occupancy, 1);
    chk("mc_flag", rc_mc, 1);
    chk("mc_list", rc_dstList, 16'h00A5);
    drive(1, 7, 16'h0, 1, 0);
    cyc();
    chk("drop2_pulse", drop, 1);
    chk("drop2_occ", occupancy, 1);
    drive(0, 0, 16'h0, 0, 1);
    cyc();
    chk("drop2_clear", drop, 0);
    chk("mc_drained", occupancy, 0);

    // Head blocked for 20 cycles, then released.
    drive(1, 2, 16'h1, 0, 0);
    cyc();
    drive(0, 0, 16'h0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc();
`ifdef INJ_STARVE_CNT_EN
      chk($sformatf("starve_k%0d", k), starve, (k >= 16) ? 1 : 0);
`else
      chk($sformatf("starve_k%0d", k), starve, 0);
`endif
    end
    drive(0, 0, 16'h0, 0, 1);
    cyc();
    chk("starve_after_pop", starve, 0);
    chk("starve_pop_occ", occupancy, 0);

    // Asynchronous reset between edges with two flits queued.
    drive(1, 8, 16'h1, 0, 0);
    cyc();
    drive(1, 9, 16'h1, 0, 0);
    cyc();
    drive(0, 0, 16'h0, 0, 0);
    chk("arst_pre_occ", occupancy, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rc_valid", rc_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_ready", inj_ready, 1);
    chk("arst_rc_dst", rc_dst, 0);
    #3 rst_n = 1'b1;
    cyc();
    chk("arst_post_occ", occupancy, 0);
    drive(1, 5, 16'h1, 0, 0);
    cyc();
    drive(0, 0, 16'h0, 0, 1);
    chk("arst_repush_dst", rc_dst, 5);
    chk("arst_repush_occ", occupancy, 1);
    cyc();
    chk("arst_final_occ", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
